boss_bullet_arbiter: RTL and testbench

Shares a fixed pool of boss projectile sprite slots between the four boss cannons (boss_shoot1..4 pulses from the boss controller).
Queues one pending shot per cannon and grants at most one slot per frame, using round-robin across cannons.
Caps the number of live bullets by difficulty and retires slots when the bullet logic reports them free.
Ages out stale requests and counts the drops for the HUD/debug display.

---
 rtl/boss_bullet_arbiter.sv | 117 +++++++++++
 tb/tb_boss_bullet_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/boss_bullet_arbiter.sv
// Shares the boss projectile sprite slots between the boss cannons.
// Grants at most one slot per frame (round-robin), caps live bullets and ages out stale shots.
module boss_bullet_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = 3,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 Boss_exists,
    input  logic [2:0]           difficulty,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_SLOTS-1:0] slot_free,
    output logic                 grant_valid,
    output logic [1:0]           grant_req,
    output logic [SLOT_W-1:0]    grant_slot,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic [NUM_REQ-1:0]   pending,
    output logic [7:0]           drop_count
);

    localparam int LIM_W = $clog2(NUM_SLOTS + 17);
    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    logic [1:0]           rr_ptr;
    logic [AGE_W-1:0]     age [NUM_REQ];

    logic [LIM_W-1:0]     active_count;
    logic [LIM_W-1:0]     limit_raw;
    logic [LIM_W-1:0]     active_limit;
    logic [1:0]           sel_req;
    logic [SLOT_W-1:0]    sel_slot;
    logic                 do_grant;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [NUM_SLOTS-1:0] slot_onehot;
    logic [NUM_REQ-1:0]   drop_onehot;
    logic [3:0]           drop_num;
    logic [8:0]           drop_sum;
    logic [NUM_REQ-1:0]   pending_next;

    // Requests are one-frame pulses with no back-pressure: a cannon's shot is
    // captured into pending and stays there until granted, aged out or flushed.
    always_comb begin
        active_count = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            active_count = active_count + LIM_W'(slot_busy[k]);
        end
        limit_raw    = LIM_W'(2) + LIM_W'({difficulty, 1'b0});
        active_limit = (limit_raw > LIM_W'(NUM_SLOTS)) ? LIM_W'(NUM_SLOTS) : limit_raw;

        // Descending search so the smallest offset from rr_ptr wins.
        sel_req = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pending[(int'(rr_ptr) + k) % NUM_REQ]) begin
                sel_req = 2'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end

        sel_slot = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (!slot_busy[k]) begin
                sel_slot = SLOT_W'(k);
            end
        end

        do_grant = Boss_exists && (|pending) && !(&slot_busy) &&
                   (active_count < active_limit);
        grant_onehot = do_grant ? (NUM_REQ'(1) << sel_req) : '0;
        slot_onehot  = do_grant ? (NUM_SLOTS'(1) << sel_slot) : '0;

        drop_num = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            drop_onehot[i] = Boss_exists && pending[i] && !grant_onehot[i] &&
                             (age[i] == AGE_W'(MAX_WAIT));
            drop_num = drop_num + 4'(drop_onehot[i]);
        end
        drop_sum = {1'b0, drop_count} + 9'(drop_num);

        pending_next = (pending & ~grant_onehot & ~drop_onehot & {NUM_REQ{Boss_exists}}) |
                       (req & {NUM_REQ{Boss_exists}});
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            grant_valid <= 1'b0;
            grant_req   <= '0;
            grant_slot  <= '0;
            slot_busy   <= '0;
            pending     <= '0;
            drop_count  <= '0;
            rr_ptr      <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                age[i] <= '0;
            end
        end else begin
            grant_valid <= do_grant;
            if (do_grant) begin
                grant_req  <= sel_req;
                grant_slot <= sel_slot;
                rr_ptr     <= 2'((int'(sel_req) + 1) % NUM_REQ);
            end
            slot_busy  <= (slot_busy & ~slot_free) | slot_onehot;
            pending    <= pending_next;
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            // A re-queue in the frame of a grant or drop starts fresh at age 0.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!Boss_exists || !pending[i] || grant_onehot[i] || drop_onehot[i]) begin
                    age[i] <= '0;
                end else begin
                    age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_boss_bullet_arbiter.sv
// Bench for boss_bullet_arbiter: table vectors, hand sequences for frame-level corner
// cases, and randomized frames checked against a procedural reference model.
module tb_boss_bullet_arbiter;

    logic       frame_clk;
    logic       rst;
    logic       boss;
    logic [2:0] diff;
    logic [3:0] req;
    logic [7:0] free;
    logic       grant_valid;
    logic [1:0] grant_req;
    logic [2:0] grant_slot;
    logic [7:0] slot_busy;
    logic [3:0] pending;
    logic [7:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    boss_bullet_arbiter dut (
        .frame_clk  (frame_clk),
        .Reset      (rst),
        .Boss_exists(boss),
        .difficulty (diff),
        .req        (req),
        .slot_free  (free),
        .grant_valid(grant_valid),
        .grant_req  (grant_req),
        .grant_slot (grant_slot),
        .slot_busy  (slot_busy),
        .pending    (pending),
        .drop_count (drop_count)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // ---------------- reference model ----------------
    bit m_pend [4];
    int m_age  [4];
    bit m_busy [8];
    int m_rr, m_drop, m_greq, m_gslot;
    bit m_gv;

    task automatic model_step();
        int lim, cnt, g, s, nd;
        bit np [4];
        int na [4];
        if (rst) begin
            foreach (m_pend[i]) begin m_pend[i] = 0; m_age[i] = 0; end
            foreach (m_busy[k]) m_busy[k] = 0;
            m_rr = 0; m_drop = 0; m_greq = 0; m_gslot = 0; m_gv = 0;
            return;
        end
        lim = 2 + 2 * int'(diff);
        if (lim > 8) lim = 8;
        cnt = 0;
        foreach (m_busy[k]) cnt += int'(m_busy[k]);
        g = -1; s = -1;
        if (boss && cnt < lim) begin
            for (int k = 0; k < 4; k++) if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
            for (int k = 0; k < 8; k++) if (s < 0 && !m_busy[k]) s = k;
            if (g < 0 || s < 0) begin g = -1; s = -1; end
        end
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            np[i] = 0; na[i] = 0;
            if (boss && i != g && m_pend[i]) begin
                if (m_age[i] == 15) nd++;
                else begin np[i] = 1; na[i] = m_age[i] + 1; end
            end
            if (boss && req[i] && !np[i]) begin np[i] = 1; na[i] = 0; end
        end
        for (int k = 0; k < 8; k++) if (free[k]) m_busy[k] = 0;
        if (s >= 0) m_busy[s] = 1;
        m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
        m_gv = (g >= 0);
        if (g >= 0) begin m_greq = g; m_gslot = s; m_rr = (g + 1) % 4; end
        for (int i = 0; i < 4; i++) begin m_pend[i] = np[i]; m_age[i] = na[i]; end
    endtask

    function automatic logic [25:0] model_tuple();
        logic [7:0] b;
        logic [3:0] p;
        for (int k = 0; k < 8; k++) b[k] = m_busy[k];
        for (int i = 0; i < 4; i++) p[i] = m_pend[i];
        return {m_gv, 2'(m_greq), 3'(m_gslot), b, p, 8'(m_drop)};
    endfunction

    function automatic logic [25:0] dut_tuple();
        return {grant_valid, grant_req, grant_slot, slot_busy, pending, drop_count};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // One frame: inputs are already driven; sample 1ns after the edge.
    task automatic step();
        @(posedge frame_clk);
        #1;
        model_step();
        chk("model", 32'(dut_tuple()), 32'(model_tuple()));
    endtask

    task automatic drive(input logic r, input logic b, input logic [2:0] d,
                         input logic [3:0] q, input logic [7:0] f);
        rst = r; boss = b; diff = d; req = q; free = f;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic       rst;
        logic       boss;
        logic [2:0] diff;
        logic [3:0] req;
        logic [7:0] free;
        logic       gv;
        logic [1:0] greq;
        logic [2:0] gslot;
        logic [7:0] busy;
        logic [3:0] pend;
        logic [7:0] drop;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic r, input logic b, input logic [2:0] d, input logic [3:0] q,
                     input logic [7:0] f, input logic gv, input logic [1:0] gr,
                     input logic [2:0] gs, input logic [7:0] bz, input logic [3:0] p);
        vec_t e;
        e.rst = r; e.boss = b; e.diff = d; e.req = q; e.free = f;
        e.gv = gv; e.greq = gr; e.gslot = gs; e.busy = bz; e.pend = p; e.drop = 8'h00;
        vq.push_back(e);
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'd0, 4'h0, 8'h00);
        // single request: queued, then granted on slot 0
        v(1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 8'h00, 4'h0);
        v(0, 1, 3, 4'h1, 8'h00, 0, 0, 0, 8'h00, 4'h1);
        v(0, 1, 3, 4'h0, 8'h00, 1, 0, 0, 8'h01, 4'h0);
        // all four cannons, round-robin from 0
        v(1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 8'h00, 4'h0);
        v(0, 1, 3, 4'hF, 8'h00, 0, 0, 0, 8'h00, 4'hF);
        v(0, 1, 3, 4'h0, 8'h00, 1, 0, 0, 8'h01, 4'hE);
        v(0, 1, 3, 4'h0, 8'h00, 1, 1, 1, 8'h03, 4'hC);
        v(0, 1, 3, 4'h0, 8'h00, 1, 2, 2, 8'h07, 4'h8);
        v(0, 1, 3, 4'h0, 8'h00, 1, 3, 3, 8'h0F, 4'h0);
        v(0, 1, 3, 4'h0, 8'h00, 0, 3, 3, 8'h0F, 4'h0);
        // rr_ptr back at 0: cannon 1 before cannon 3
        v(0, 1, 3, 4'hA, 8'h00, 0, 3, 3, 8'h0F, 4'hA);
        v(0, 1, 3, 4'h0, 8'h00, 1, 1, 4, 8'h1F, 4'h8);
        v(0, 1, 3, 4'h0, 8'h00, 1, 3, 5, 8'h3F, 4'h0);
        // fill the pool, then a free re-opens slot 5 one frame later
        v(0, 1, 3, 4'h3, 8'h00, 0, 3, 5, 8'h3F, 4'h3);
        v(0, 1, 3, 4'h0, 8'h00, 1, 0, 6, 8'h7F, 4'h2);
        v(0, 1, 3, 4'h0, 8'h00, 1, 1, 7, 8'hFF, 4'h0);
        v(0, 1, 3, 4'h2, 8'h00, 0, 1, 7, 8'hFF, 4'h2);
        v(0, 1, 3, 4'h0, 8'h20, 0, 1, 7, 8'hDF, 4'h2);
        v(0, 1, 3, 4'h0, 8'h00, 1, 1, 5, 8'hFF, 4'h0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].boss, vq[i].diff, vq[i].req, vq[i].free);
            step();
            chk($sformatf("vec%0d", i), 32'(dut_tuple()),
                32'({vq[i].gv, vq[i].greq, vq[i].gslot, vq[i].busy, vq[i].pend, vq[i].drop}));
        end

        // cap at difficulty 0, double drop, free then grant a frame later
        drive(1, 0, 0, 4'h0, 8'h00); step();
        drive(0, 1, 0, 4'hF, 8'h00); step();
        drive(0, 1, 0, 4'h0, 8'h00); step();
        chk("d0_g0", {grant_valid, grant_req, grant_slot}, {1'b1, 2'd0, 3'd0});
        step();
        chk("d0_g1", {grant_valid, grant_req, grant_slot}, {1'b1, 2'd1, 3'd1});
        for (int i = 0; i < 13; i++) step();
        chk("d0_wait_pend", pending, 4'hC);
        chk("d0_wait_drop", drop_count, 8'd0);
        step();
        chk("d0_drop_pend", pending, 4'h0);
        chk("d0_drop_cnt", drop_count, 8'd2);
        drive(0, 1, 0, 4'h4, 8'h01); step();
        chk("free_no_grant", {grant_valid, slot_busy, pending}, {1'b0, 8'h02, 4'h4});
        drive(0, 1, 0, 4'h0, 8'h00); step();
        chk("free_grant", {grant_valid, grant_req, grant_slot, slot_busy}, {1'b1, 2'd2, 3'd0, 8'h03});

        // Boss_exists low flushes the queue but keeps the slots
        drive(1, 0, 0, 4'h0, 8'h00); step();
        drive(0, 1, 0, 4'h3, 8'h00); step();
        drive(0, 1, 0, 4'h0, 8'h00); step(); step();
        drive(0, 1, 0, 4'h4, 8'h00); step();
        drive(0, 1, 0, 4'h0, 8'h00);
        for (int i = 0; i < 7; i++) step();
        chk("boss_pre_pend", pending, 4'h4);
        drive(0, 0, 0, 4'h0, 8'h01); step();
        chk("boss_off", {grant_valid, slot_busy, pending, drop_count}, {1'b0, 8'h02, 4'h0, 8'h00});
        drive(0, 0, 0, 4'hF, 8'h00); step();
        chk("boss_off_req", {grant_valid, slot_busy, pending}, {1'b0, 8'h02, 4'h0});

        // request on the grant frame re-queues; then saturate drop_count
        drive(1, 0, 0, 4'h0, 8'h00); step();
        drive(0, 1, 3, 4'h1, 8'h00); step();
        step();
        chk("requeue_g", {grant_valid, grant_req, grant_slot, pending}, {1'b1, 2'd0, 3'd0, 4'h1});
        drive(0, 1, 3, 4'h0, 8'h00); step();
        chk("requeue_g2", {grant_valid, grant_req, grant_slot, slot_busy, pending},
            {1'b1, 2'd0, 3'd1, 8'h03, 4'h0});
        drive(0, 1, 0, 4'hF, 8'h00);
        for (int i = 0; i < 17; i++) step();
        chk("sat_first", drop_count, 8'd4);
        for (int i = 0; i < 1040; i++) step();
        chk("sat_final", drop_count, 8'd255);

        // randomized frames against the model
        drive(1, 0, 0, 4'h0, 8'h00); step();
        boss = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) boss = ~boss;
            if ($urandom_range(0, 49) == 0) diff = 3'($urandom_range(0, 7));
            req  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            free = 8'($urandom) & 8'($urandom) & 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
